title_sequencer: RTL and testbench
==================================

Name: title_sequencer

Overview:
- Frame-level controller for the title-screen text overlay.
- Drives the renderer's top-left position, colour and enable.
- Sequences the overlay through four phases: scroll-in, blinking hold until the start button, scroll-out, and a one-cycle game-start handoff.
- Sits between the VGA sync counters and the title renderer/ROM; the game FSM consumes game_start.

Parameters:
- X_POS, 225: fixed left x coordinate of the title (pixels).
- START_Y, 440: y coordinate at the beginning of scroll-in.
- TARGET_Y, 5: resting y coordinate.
- STEP, 4: pixels moved per frame during scroll-in and scroll-out.
- BLINK_FRAMES, 30: frames per blink half-period in HOLD.
- FRAME_LINE, 480: VCount value that marks the frame tick (first blanking line).

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous active-low reset
- HCount  in  10  horizontal pixel counter from sync generator
- VCount  in  10  vertical line counter from sync generator
- title_req  in  1  level; high requests the title screen
- start_btn  in  1  raw, asynchronous start button
- pos_x_l  out  10  title left x (constant X_POS)
- pos_y_t  out  10  title top y
- title_en  out  1  renderer enable; gates titleon
- title_rgb  out  3  colour applied to lit title pixels
- busy  out  1  high in any state except IDLE
- game_start  out  1  one-clk pulse when the sequence completes

Behaviour:
- Reset (rst_n low at a clk edge) puts outputs in these states:
  - state = IDLE, pos_y_t = START_Y, pos_x_l = X_POS
  - title_en = 0, title_rgb = 3'b001
  - busy = 0, game_start = 0
  - blink counter = 0, button synchroniser cleared
- Reset mid-sequence aborts immediately to these values; no game_start is issued.
- Frame tick:
  - Condition is HCount==0 && VCount==FRAME_LINE.
  - It is registered, and the tick is its rising edge: exactly one clk pulse per frame, independent of the pixel/clk ratio.
- Start button:
  - Two-flop synchroniser, then rising-edge detect giving a one-clk press pulse.
  - A held button produces one press only.
- IDLE: title_en = 0.
  - title_req = 1 → SCROLL, with pos_y_t loaded with START_Y on the same edge.
- SCROLL: title_en = 1, rgb = 001.
  - On each tick, pos_y_t = max(pos_y_t − STEP, TARGET_Y); compute in 11 bits so there is no underflow wrap.
  - When pos_y_t reaches TARGET_Y → HOLD.
  - A press in SCROLL snaps pos_y_t to TARGET_Y → HOLD; the press is consumed and does not also exit.
- HOLD: the blink counter counts ticks.
  - At BLINK_FRAMES−1 the counter wraps to 0 and title_en toggles.
  - Entry sets title_en = 1 and counter = 0.
  - A press → EXIT, forcing title_en = 1.
- EXIT: on each tick:
  - If pos_y_t ≤ STEP → DONE, title_en = 0.
  - Otherwise pos_y_t −= STEP.
  - Presses are ignored.
- DONE: game_start = 1 for exactly one clk, then → IDLE with pos_y_t = START_Y.
  - If title_req is still high, the next edge restarts SCROLL.
- title_req dropping in SCROLL or HOLD → IDLE next edge, title_en = 0, no game_start.
- title_req dropping in EXIT has no effect; the sequence completes.
- A tick and a press in the same clk:
  - In SCROLL, the press wins (snap).
  - In HOLD, the press wins; the blink counter does not advance.
- All state and output changes occur on clk edges only; outputs are registered.

Optional Feature:
- TITLE_COLOR_CYCLE_EN defined:
  - In HOLD, title_en stays 1.
  - title_rgb advances 001→010→…→111→001 at each blink-counter wrap (never 000).
  - title_rgb returns to 001 on EXIT entry.
- TITLE_COLOR_CYCLE_EN undefined:
  - Blink-by-enable as above.
  - title_rgb fixed at 001.

Decomposition:
- Package title_pkg holds:
  - state encoding (IDLE, SCROLL, HOLD, EXIT, DONE)
  - TITLE_WIDTH = 216, TITLE_HEIGHT = 36
  - default X_POS and TARGET_Y
  - H_VISIBLE = 640, V_VISIBLE = 480
- Sub-module frame_tick_gen: registered compare plus rising-edge detect of the frame-tick condition.
- Button synchroniser stays inline.

Test Plan:
- Reset: hold rst_n low 3 clk with title_req = 1 → pos_y_t = 440, title_en = 0, busy = 0, rgb = 001. Then rst_n high → SCROLL, busy = 1.
- Scroll-in clamp with defaults: after 108 ticks pos_y_t = 8; tick 109 gives pos_y_t = 5 and state HOLD. No tick ever yields a value < 5.
- Blink: in HOLD, title_en toggles every 30 ticks. Over 120 ticks, 4 toggles; no toggle between ticks.
- Press in SCROLL at pos_y_t = 300 → next clk pos_y_t = 5, state HOLD, still in HOLD after 2 more clk.
- Exit: press in HOLD, then tick 1 gives pos_y_t = 1, tick 2 gives title_en = 0. game_start is high exactly 1 clk, then IDLE.
- title_req dropped mid-HOLD → IDLE, title_en = 0, game_start never asserts. Button held high 1000 clk yields a single press.

Source files
------------

// File: rtl/title_pkg.sv
// Shared definitions for the title-screen overlay sequencer.
// Contents: FSM state encoding, title bitmap geometry, default placement
// and the visible raster size of the VGA timing in use.
package title_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StScroll,
    StHold,
    StExit,
    StDone
  } title_state_e;

  localparam int unsigned TITLE_WIDTH      = 216;
  localparam int unsigned TITLE_HEIGHT     = 36;
  localparam int unsigned X_POS_DEFAULT    = 225;
  localparam int unsigned TARGET_Y_DEFAULT = 5;
  localparam int unsigned H_VISIBLE        = 640;
  localparam int unsigned V_VISIBLE        = 480;

endpackage

// File: rtl/title_sequencer_if.sv
// Signal bundle between the sync counters / start button / title renderer
// and the title sequencer.
//   HCount, VCount : raster position from the sync generator
//   title_req      : level request for the title screen
//   start_btn      : raw asynchronous start button
//   pos_x_l/pos_y_t: title top-left position for the renderer
//   title_en       : renderer enable, title_rgb: lit-pixel colour
//   busy           : sequencer not idle, game_start: one-clk handoff pulse
// Modports: master drives the inputs (system/testbench), slave is the sequencer.
interface title_sequencer_if;
  logic [9:0] HCount;
  logic [9:0] VCount;
  logic       title_req;
  logic       start_btn;
  logic [9:0] pos_x_l;
  logic [9:0] pos_y_t;
  logic       title_en;
  logic [2:0] title_rgb;
  logic       busy;
  logic       game_start;

  modport master (
    output HCount, VCount, title_req, start_btn,
    input  pos_x_l, pos_y_t, title_en, title_rgb, busy, game_start
  );

  modport slave (
    input  HCount, VCount, title_req, start_btn,
    output pos_x_l, pos_y_t, title_en, title_rgb, busy, game_start
  );
endinterface

// File: rtl/frame_tick_gen.sv
// Frame tick generator: registers the "first blanking line, column 0"
// compare and emits a single-clk pulse on its rising edge, so one tick per
// frame regardless of how many clks each pixel lasts.
// Ports: clk, rst_n (sync, active low), h_count/v_count (raster position),
//        tick (one-clk pulse per frame).
module frame_tick_gen
  import title_pkg::*;
#(
  parameter int unsigned FRAME_LINE = V_VISIBLE
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [9:0] h_count,
  input  logic [9:0] v_count,
  output logic       tick
);

  logic cond_q;
  logic cond_prev_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cond_q      <= 1'b0;
      cond_prev_q <= 1'b0;
    end else begin
      cond_q      <= (h_count == 10'd0) && (v_count == 10'(FRAME_LINE));
      cond_prev_q <= cond_q;
    end
  end

  assign tick = cond_q & ~cond_prev_q;

endmodule

// File: rtl/title_sequencer.sv
// Title-screen overlay sequencer: scrolls the title in from START_Y to
// TARGET_Y, blinks it until the start button is pressed, scrolls it out
// upwards and then issues a one-clk game_start.
// Ports: clk, rst_n (sync, active low), bus (title_sequencer_if.slave).
// Build option: define TITLE_COLOR_CYCLE_EN to keep the title lit in HOLD
// and cycle title_rgb through 001..111 instead of blinking the enable.
module title_sequencer
  import title_pkg::*;
#(
  parameter int unsigned X_POS        = X_POS_DEFAULT,
  parameter int unsigned START_Y      = 440,
  parameter int unsigned TARGET_Y     = TARGET_Y_DEFAULT,
  parameter int unsigned STEP         = 4,
  parameter int unsigned BLINK_FRAMES = 30,
  parameter int unsigned FRAME_LINE   = V_VISIBLE
) (
  input logic               clk,
  input logic               rst_n,
  title_sequencer_if.slave  bus
);

  localparam int unsigned BlinkW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  title_state_e      state_q, state_d;
  logic [9:0]        pos_y_q, pos_y_d;
  logic              en_q, en_d;
  logic [2:0]        rgb_q, rgb_d;
  logic [BlinkW-1:0] blink_q, blink_d;
  logic              busy_q, busy_d;
  logic              game_start_q, game_start_d;

  logic btn_meta_q, btn_sync_q, btn_prev_q;
  logic press;
  logic tick;
  logic [9:0] scroll_y;

  frame_tick_gen #(
    .FRAME_LINE (FRAME_LINE)
  ) u_frame_tick_gen (
    .clk     (clk),
    .rst_n   (rst_n),
    .h_count (bus.HCount),
    .v_count (bus.VCount),
    .tick    (tick)
  );

  // Two-flop synchroniser plus edge detect: a held button gives one press.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      btn_meta_q <= 1'b0;
      btn_sync_q <= 1'b0;
      btn_prev_q <= 1'b0;
    end else begin
      btn_meta_q <= bus.start_btn;
      btn_sync_q <= btn_meta_q;
      btn_prev_q <= btn_sync_q;
    end
  end

  assign press = btn_sync_q & ~btn_prev_q;

  // Clamp at TARGET_Y; the compare is done in 11 bits so pos - STEP cannot wrap.
  assign scroll_y = ({1'b0, pos_y_q} < 11'(STEP + TARGET_Y)) ? 10'(TARGET_Y)
                                                             : pos_y_q - 10'(STEP);

  always_comb begin
    state_d      = state_q;
    pos_y_d      = pos_y_q;
    en_d         = en_q;
    rgb_d        = rgb_q;
    blink_d      = blink_q;
    game_start_d = 1'b0;

    unique case (state_q)
      StIdle: begin
        en_d  = 1'b0;
        rgb_d = 3'b001;
        if (bus.title_req) begin
          state_d = StScroll;
          pos_y_d = 10'(START_Y);
          en_d    = 1'b1;
        end
      end
      StScroll: begin
        if (!bus.title_req) begin
          state_d = StIdle;
          pos_y_d = 10'(START_Y);
          en_d    = 1'b0;
          rgb_d   = 3'b001;
        end else if (press) begin
          // Snap; the press is consumed here and does not also exit.
          state_d = StHold;
          pos_y_d = 10'(TARGET_Y);
          en_d    = 1'b1;
          blink_d = '0;
        end else if (tick) begin
          pos_y_d = scroll_y;
          if (scroll_y == 10'(TARGET_Y)) begin
            state_d = StHold;
            en_d    = 1'b1;
            blink_d = '0;
          end
        end
      end
      StHold: begin
        if (!bus.title_req) begin
          state_d = StIdle;
          pos_y_d = 10'(START_Y);
          en_d    = 1'b0;
          rgb_d   = 3'b001;
        end else if (press) begin
          state_d = StExit;
          en_d    = 1'b1;
          rgb_d   = 3'b001;
        end else if (tick) begin
          if (blink_q == BlinkW'(BLINK_FRAMES - 1)) begin
            blink_d = '0;
`ifdef TITLE_COLOR_CYCLE_EN
            rgb_d = (rgb_q == 3'b111) ? 3'b001 : rgb_q + 3'd1;
`else
            en_d  = ~en_q;
`endif
          end else begin
            blink_d = blink_q + BlinkW'(1);
          end
        end
      end
      StExit: begin
        // title_req and presses are ignored: the scroll-out always completes.
        if (tick) begin
          if (pos_y_q <= 10'(STEP)) begin
            state_d      = StDone;
            en_d         = 1'b0;
            game_start_d = 1'b1;
          end else begin
            pos_y_d = pos_y_q - 10'(STEP);
          end
        end
      end
      StDone: begin
        state_d = StIdle;
        pos_y_d = 10'(START_Y);
      end
      default: state_d = StIdle;
    endcase

    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      pos_y_q      <= 10'(START_Y);
      en_q         <= 1'b0;
      rgb_q        <= 3'b001;
      blink_q      <= '0;
      busy_q       <= 1'b0;
      game_start_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pos_y_q      <= pos_y_d;
      en_q         <= en_d;
      rgb_q        <= rgb_d;
      blink_q      <= blink_d;
      busy_q       <= busy_d;
      game_start_q <= game_start_d;
    end
  end

  assign bus.pos_x_l    = 10'(X_POS);
  assign bus.pos_y_t    = pos_y_q;
  assign bus.title_en   = en_q;
  assign bus.title_rgb  = rgb_q;
  assign bus.busy       = busy_q;
  assign bus.game_start = game_start_q;

endmodule

// File: tb/tb_title_sequencer.sv
// Bench for title_sequencer: directed scenarios plus a randomized run, all
// checked against an event-level model of the overlay sequence.
module tb_title_sequencer;

  localparam int XPos      = 225;
  localparam int StartY    = 440;
  localparam int TargetY   = 5;
  localparam int Step      = 4;
  localparam int Blink     = 30;
  localparam int FrameLine = 480;

  localparam int PIdle   = 0;
  localparam int PScroll = 1;
  localparam int PHold   = 2;
  localparam int PExit   = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  title_sequencer_if bus ();

  title_sequencer #(
    .X_POS        (XPos),
    .START_Y      (StartY),
    .TARGET_Y     (TargetY),
    .STEP         (Step),
    .BLINK_FRAMES (Blink),
    .FRAME_LINE   (FrameLine)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Model of the overlay as seen by the renderer.
  int m_phase, m_y, m_en, m_rgb, m_blink, m_gs;
  bit m_y_valid;
  bit req;

  int gs_cycles = 0;
  always @(negedge clk) if (bus.game_start === 1'b1) gs_cycles++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic compare_all(input string tag);
    if (m_y_valid) check({tag, ".pos_y"}, 32'(bus.pos_y_t), m_y);
    check({tag, ".pos_x"}, 32'(bus.pos_x_l), XPos);
    check({tag, ".en"}, 32'(bus.title_en), m_en);
    check({tag, ".rgb"}, 32'(bus.title_rgb), m_rgb);
    check({tag, ".busy"}, 32'(bus.busy), (m_phase != PIdle) ? 1 : 0);
  endtask

  function automatic void enter_hold();
    m_phase = PHold; m_en = 1; m_blink = 0;
  endfunction

  function automatic void to_idle_or_restart();
    m_y = StartY; m_y_valid = 1; m_rgb = 1;
    m_phase = req ? PScroll : PIdle;
    m_en = req ? 1 : 0;
  endfunction

  function automatic void model_tick();
    case (m_phase)
      PScroll: begin
        m_y = (m_y - Step < TargetY) ? TargetY : m_y - Step;
        if (m_y == TargetY) enter_hold();
      end
      PHold: begin
        m_blink++;
        if (m_blink == Blink) begin
          m_blink = 0;
`ifdef TITLE_COLOR_CYCLE_EN
          m_rgb = (m_rgb == 7) ? 1 : m_rgb + 1;
`else
          m_en = 1 - m_en;
`endif
        end
      end
      PExit: begin
        if (m_y <= Step) begin m_gs++; to_idle_or_restart(); end
        else m_y = m_y - Step;
      end
      default: ;
    endcase
  endfunction

  function automatic void model_press();
    if (m_phase == PScroll) begin m_y = TargetY; enter_hold(); end
    else if (m_phase == PHold) begin m_phase = PExit; m_en = 1; m_rgb = 1; end
  endfunction

  function automatic void model_req(input bit v);
    req = v;
    if (v && m_phase == PIdle) begin
      m_phase = PScroll; m_y = StartY; m_y_valid = 1; m_en = 1; m_rgb = 1;
    end else if (!v && (m_phase == PScroll || m_phase == PHold)) begin
      m_phase = PIdle; m_en = 0; m_rgb = 1; m_y_valid = 0;
    end
  endfunction

  task automatic off_coords();
    if ($urandom_range(0, 1) == 1) begin
      bus.HCount = 10'd0;
      bus.VCount = 10'($urandom_range(0, FrameLine - 1));
    end else begin
      bus.HCount = 10'($urandom_range(1, 799));
      bus.VCount = 10'($urandom_range(0, 524));
    end
  endtask

  // Frame condition held for 1..3 clks to mimic slow pixel clocks.
  task automatic do_tick();
    int k;
    k = $urandom_range(1, 3);
    @(negedge clk);
    bus.HCount = 10'd0;
    bus.VCount = 10'(FrameLine);
    repeat (k) @(negedge clk);
    off_coords();
    repeat (3) @(negedge clk);
    model_tick();
  endtask

  task automatic do_press(input int extra);
    @(negedge clk);
    bus.start_btn = 1'b1;
    repeat (3 + extra) @(negedge clk);
    bus.start_btn = 1'b0;
    repeat (3) @(negedge clk);
    model_press();
  endtask

  // Press pulse and tick pulse land on the same clk.
  task automatic do_combo();
    @(negedge clk);
    bus.start_btn = 1'b1;
    @(negedge clk);
    bus.HCount = 10'd0;
    bus.VCount = 10'(FrameLine);
    @(negedge clk);
    off_coords();
    @(negedge clk);
    bus.start_btn = 1'b0;
    repeat (3) @(negedge clk);
    if (m_phase == PScroll || m_phase == PHold) model_press();
    else model_tick();
  endtask

  task automatic set_req(input bit v);
    @(negedge clk);
    bus.title_req = v;
    repeat (2) @(negedge clk);
    model_req(v);
  endtask

  task automatic reset_model();
    m_phase = PIdle; m_y = StartY; m_y_valid = 1; m_en = 0; m_rgb = 1; m_blink = 0;
  endtask

  initial begin
    int toggles;
    logic prev_en;

    bus.HCount = 10'd100;
    bus.VCount = 10'd100;
    bus.start_btn = 1'b0;
    bus.title_req = 1'b1;
    req = 1'b1;
    m_gs = 0;
    reset_model();

    // Reset with title_req already high.
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    compare_all("reset");
    check("reset.game_start", 32'(bus.game_start), 0);
    rst_n = 1'b1;
    @(negedge clk);
    m_phase = PIdle;
    model_req(1'b1);
    compare_all("reset_release");

    // Scroll-in down to the clamp.
    for (int i = 1; i <= 109; i++) begin
      do_tick();
      compare_all("scroll");
      if (i == 108) check("scroll.y_at_108", 32'(bus.pos_y_t), 8);
    end
    check("scroll.y_at_109", 32'(bus.pos_y_t), TargetY);

    // Blink over 120 ticks.
    toggles = 0;
    for (int i = 0; i < 120; i++) begin
      prev_en = bus.title_en;
      do_tick();
      if (bus.title_en !== prev_en) toggles++;
      compare_all("blink");
    end
`ifdef TITLE_COLOR_CYCLE_EN
    check("blink.toggles", 32'(toggles), 0);
`else
    check("blink.toggles", 32'(toggles), 4);
`endif

    // Exit with req dropped in EXIT so the sequence ends in IDLE.
    do_press(0);
    compare_all("exit_entry");
    set_req(1'b0);
    compare_all("exit_req_low");
    do_tick();
    check("exit.y_tick1", 32'(bus.pos_y_t), 1);
    compare_all("exit_tick1");
    do_tick();
    compare_all("exit_tick2");
    check("exit.game_start_count", 32'(gs_cycles), m_gs);

    // Press in SCROLL at y = 300.
    set_req(1'b1);
    for (int i = 0; i < 35; i++) do_tick();
    check("snap.y_before", 32'(bus.pos_y_t), 300);
    do_press(0);
    compare_all("snap");
    repeat (2) @(negedge clk);
    compare_all("snap_stay");

    // Drop title_req mid-HOLD.
    for (int i = 0; i < 5; i++) do_tick();
    set_req(1'b0);
    compare_all("drop_hold");
    check("drop.game_start_count", 32'(gs_cycles), m_gs);

    // Button held 1000 clk in SCROLL: a single press only.
    set_req(1'b1);
    for (int i = 0; i < 3; i++) do_tick();
    @(negedge clk);
    bus.start_btn = 1'b1;
    repeat (1000) @(negedge clk);
    model_press();
    compare_all("held_btn");
    bus.start_btn = 1'b0;
    repeat (3) @(negedge clk);
    compare_all("held_btn_release");

    // Same-clk tick and press in HOLD, then in SCROLL.
    for (int i = 0; i < 7; i++) do_tick();
    do_combo();
    compare_all("combo_hold");
    do_tick();
    do_tick();
    compare_all("combo_exit_done");
    for (int i = 0; i < 10; i++) do_tick();
    do_combo();
    compare_all("combo_scroll");

    // Reset mid-sequence.
    @(negedge clk);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    reset_model();
    compare_all("mid_reset");
    rst_n = 1'b1;
    @(negedge clk);
    model_req(1'b1);
    compare_all("mid_reset_release");

    // Randomized operations.
    for (int n = 0; n < 400; n++) begin
      int op;
      op = $urandom_range(0, 99);
      if (op < 62) do_tick();
      else if (op < 77) do_press($urandom_range(0, 6));
      else if (op < 82) do_combo();
      else if (op < 90) set_req(!req);
      else repeat ($urandom_range(1, 8)) @(negedge clk);
      compare_all("random");
    end

    repeat (4) @(negedge clk);
    check("final.game_start_count", 32'(gs_cycles), m_gs);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
